// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: FSM states, default baud divider,
// and the sub-bit positions used for majority sampling.
package uart_rx_fifo_pkg;

  // Receiver frame states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // 50 MHz system clock, 9600 baud, 8 oversample ticks per bit
  localparam int DIV_DEFAULT = 651;

  // Sub-bit positions (8 ticks per bit): three samples around mid-bit,
  // decision at the last tick of the bit
  localparam logic [2:0] SAMPLE_A = 3'd3;
  localparam logic [2:0] SAMPLE_B = 3'd4;
  localparam logic [2:0] SAMPLE_C = 3'd5;
  localparam logic [2:0] BIT_LAST = 3'd7;

  // Two-of-three vote over the mid-bit samples
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO. Storage is a plain array with a
// registered read port; the head register is pre-loaded with the entry that
// will be at the head after this cycle's push/pop, so pop_data is valid in
// the same cycle that empty deasserts.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      level_reg;
  logic [AW:0]      level_next;
  logic [WIDTH-1:0] head_reg;
  logic             do_pop;
  logic             do_push;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign level = level_reg;

  // Pop only when something is there; a push into a full FIFO only succeeds
  // when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Read address the head register must track after this cycle
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (do_pop) rd_ptr_next = rd_ptr_reg + 1'b1;
  end

  // Occupancy bookkeeping: simultaneous push and pop leave it unchanged
  always_comb begin
    level_next = level_reg;
    unique case ({do_push, do_pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Storage write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Registered read of the next head, bypassing a write to that same slot
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
      head_reg <= push_data;
    end else begin
      head_reg <= mem[rd_ptr_next];
    end
  end

  // Drive zero while empty so stale storage never leaks out
  assign pop_data = empty ? '0 : head_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 8x oversampling and majority voting, feeding a
// first-word-fall-through byte FIFO. Framing errors and overruns are
// reported as single-cycle pulses.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxd,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     frame_err,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          rxd_sync;
  logic [TW-1:0] tick_cnt_reg;
  logic          tick;
  rx_state_t     state_reg;
  rx_state_t     state_next;
  logic [2:0]    sub_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [2:0]    sample_reg;
  logic [7:0]    shift_reg;
  logic          bit_end;
  logic          bit_val;
  logic          push_byte;
  logic          stop_bad;
  logic          frame_err_reg;
  logic          overrun_reg;
  logic          fifo_full;
  logic          fifo_empty;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
    end
  end

  assign rxd_sync = sync2_reg;

  // Free-running oversample divider, one tick every DIV clocks
  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt_reg <= '0;
    else             tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  assign tick    = (tick_cnt_reg == TW'(DIV - 1));
  assign bit_end = tick && (sub_cnt_reg == BIT_LAST);
  assign bit_val = majority3(sample_reg);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next-state: all moves happen on tick cycles only
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (tick && !rxd_sync) state_next = ST_START;
      ST_START: if (bit_end) state_next = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_end && (bit_idx_reg == 3'd7)) state_next = ST_STOP;
      ST_STOP:  if (bit_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: the stop-bit verdict either delivers the byte or flags it
  always_comb begin
    push_byte = 1'b0;
    stop_bad  = 1'b0;
    if (state_reg == ST_STOP && bit_end) begin
      push_byte = bit_val;
      stop_bad  = !bit_val;
    end
  end

  // Bit timing, mid-bit sampling and LSB-first byte assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_reg <= '0;
      bit_idx_reg <= '0;
      sample_reg  <= 3'b111;
      shift_reg   <= '0;
    end else if (tick) begin
      if (state_reg == ST_IDLE) begin
        sub_cnt_reg <= '0;
        bit_idx_reg <= '0;
      end else begin
        sub_cnt_reg <= sub_cnt_reg + 1'b1;
        if (sub_cnt_reg == SAMPLE_A) sample_reg[0] <= rxd_sync;
        if (sub_cnt_reg == SAMPLE_B) sample_reg[1] <= rxd_sync;
        if (sub_cnt_reg == SAMPLE_C) sample_reg[2] <= rxd_sync;
        if (sub_cnt_reg == BIT_LAST) begin
          if (state_reg == ST_START) bit_idx_reg <= '0;
          if (state_reg == ST_DATA) begin
            shift_reg   <= {bit_val, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
          end
        end
      end
    end
  end

  // Error pulses, registered so they line up with the FIFO level update
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      overrun_reg   <= push_byte && fifo_full && !(rx_valid && rx_ready);
    end
  end

  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign rx_valid  = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_byte),
    .push_data (shift_reg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Each sent frame is turned into a
// scheduled event (the clock edge at which its byte lands or its framing
// error is reported) computed from the frame start, the tick phase since
// reset and the fixed 80-tick frame length. A queue-based FIFO model is
// advanced per edge and compared against the DUT every cycle.
module tb_uart_rx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int BIT   = 8 * DIV;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic [LW-1:0] fifo_level;

  uart_rx_fifo #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pc;
    bit         good;
    logic [7:0] data;
  } ev_t;

  int         cyc = 0;
  int         p0 = 0;
  ev_t        ev_q[$];
  logic [7:0] mq[$];
  logic [7:0] got[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         vcnt = 0;
  int         last_pc = 0;
  bit         abort = 0;
  bit         rnd_on = 0;

  // Edge counter and the edge index of the last reset edge (tick phase origin)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) p0 <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int got_at(input int i);
    return (got.size() > i) ? int'(got[i]) : -1;
  endfunction

  // Reference model and per-cycle comparison, sampled on the falling edge
  initial begin : monitor
    bit exp_f;
    bit exp_o;
    bit rst_prev;
    bit ready_prev;
    rst_prev   = 1'b1;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      exp_f = 1'b0;
      exp_o = 1'b0;
      if (rst_prev) begin
        mq.delete();
        ev_q.delete();
      end else begin
        if (mq.size() > 0 && ready_prev) void'(mq.pop_front());
        if (ev_q.size() > 0 && ev_q[0].pc == cyc) begin
          if (!ev_q[0].good)           exp_f = 1'b1;
          else if (mq.size() >= DEPTH) exp_o = 1'b1;
          else                         mq.push_back(ev_q[0].data);
          void'(ev_q.pop_front());
        end
      end
      if (cyc >= 1) begin
        check("rx_valid", int'(rx_valid), int'(mq.size() != 0));
        check("fifo_level", int'(fifo_level), mq.size());
        check("frame_err", int'(frame_err), int'(exp_f));
        check("overrun", int'(overrun), int'(exp_o));
        if (mq.size() > 0) check("rx_data", int'(rx_data), int'(mq[0]));
        if (rst_prev) check("rx_data_reset", int'(rx_data), 0);
      end
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid) vcnt++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      rst_prev   = rst;
      ready_prev = rx_ready;
    end
  end

  // Send one 8N1 frame; schedules the edge at which the result must appear
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    int e;
    int d;
    logic [9:0] fr;
    @(posedge clk); #2;
    e = cyc;
    // first tick cycle that can see the start bit through the synchronizer
    d = e + 2;
    while (((d - p0) % DIV) != DIV - 1) d++;
    // 8 ticks each for start, 8 data bits and stop, then one edge to land
    last_pc = d + 80 * DIV + 1;
    ev_q.push_back('{last_pc, stop_ok, b});
    fr = {stop_ok, b, 1'b0};
    for (int c = 0; c < 10 * BIT; c++) begin
      if (abort) break;
      rxd = fr[c / BIT];
      @(posedge clk); #2;
    end
    rxd = 1'b1;
    if (!abort) repeat (gap) @(posedge clk);
  endtask

  task automatic clear_counts();
    got.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    vcnt     = 0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nbad_sent;
    logic [7:0] b;
    bit ok;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_data", int'(rx_data), 0);
    @(posedge clk); #2;

    // Two back-to-back bytes with the consumer always ready
    clear_counts();
    rx_ready = 1'b1;
    send_frame(8'h32, 1'b1, 20);
    send_frame(8'h31, 1'b1, 20);
    repeat (10) @(posedge clk); #2;
    check("t1_count", got.size(), 2);
    check("t1_byte0", got_at(0), 'h32);
    check("t1_byte1", got_at(1), 'h31);
    check("t1_valid_cycles", vcnt, 2);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_ovr", ovr_cnt, 0);

    // 8-clock low glitch on an idle line must be rejected
    clear_counts();
    rxd = 1'b0;
    repeat (8) @(posedge clk); #2;
    rxd = 1'b1;
    repeat (400) @(posedge clk); #2;
    check("t2_valid_cycles", vcnt, 0);
    check("t2_ferr", ferr_cnt, 0);

    // Bad stop bit
    clear_counts();
    send_frame(8'h45, 1'b0, 20);
    repeat (10) @(posedge clk); #2;
    check("t3_ferr", ferr_cnt, 1);
    check("t3_level", int'(fifo_level), 0);
    check("t3_valid_cycles", vcnt, 0);

    // Nine bytes into an eight-deep FIFO with no consumer
    clear_counts();
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 1'b1, 12);
    repeat (5) @(posedge clk); #2;
    check("t4_level_full", int'(fifo_level), 8);
    check("t4_ovr", ovr_cnt, 1);
    rx_ready = 1'b1;
    repeat (20) @(posedge clk); #2;
    rx_ready = 1'b0;
    check("t4_drained", got.size(), 8);
    for (int i = 0; i < 8; i++) check("t4_drain_byte", got_at(i), 'h30 + i);

    // Full FIFO; consumer pops on exactly the cycle of the next push
    clear_counts();
    for (int i = 0; i < 8; i++) send_frame(8'h50 + 8'(i), 1'b1, 12);
    fork
      send_frame(8'h58, 1'b1, 12);
    join_none
    @(posedge clk); #3;
    while (cyc < last_pc - 1) begin
      @(posedge clk); #2;
    end
    rx_ready = 1'b1;
    @(posedge clk); #2;
    rx_ready = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t5_level", int'(fifo_level), 8);
    check("t5_head", int'(rx_data), 'h51);
    check("t5_ovr", ovr_cnt, 0);
    check("t5_popped", got_at(0), 'h50);
    @(posedge clk); #2;
    rx_ready = 1'b1;
    repeat (20) @(posedge clk); #2;
    rx_ready = 1'b0;
    check("t5_total", got.size(), 9);
    for (int i = 0; i < 9; i++) check("t5_drain_byte", got_at(i), 'h50 + i);

    // Reset in the middle of data bit 4 of 0x44, then a clean 0x41
    clear_counts();
    rx_ready = 1'b1;
    fork
      send_frame(8'h44, 1'b1, 12);
    join_none
    repeat (BIT * 5 + 16) @(posedge clk); #2;
    abort = 1'b1;
    rst   = 1'b1;
    repeat (3) @(posedge clk); #2;
    rst   = 1'b0;
    abort = 1'b0;
    repeat (20) @(posedge clk); #2;
    send_frame(8'h41, 1'b1, 20);
    repeat (10) @(posedge clk); #2;
    check("t6_count", got.size(), 1);
    check("t6_byte", got_at(0), 'h41);
    check("t6_ferr", ferr_cnt, 0);
    check("t6_ovr", ovr_cnt, 0);

    // Random bytes, random stop-bit faults, random consumer back-pressure
    clear_counts();
    nbad_sent = 0;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          rx_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #2;
        end
        rx_ready = 1'b0;
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      if (!ok) nbad_sent++;
      send_frame(b, ok, $urandom_range(8, 60));
    end
    rnd_on = 1'b0;
    repeat (3) @(posedge clk); #2;
    rx_ready = 1'b1;
    repeat (20) @(posedge clk); #2;
    check("t7_ferr", ferr_cnt, nbad_sent);
    check("t7_level_empty", int'(fifo_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
